// File: rtl/gbuff_stream_reader_if.sv
// Bundles the command, buffer-read and output-stream signals of the global buffer reader.
// master = the reader itself, slave = the environment (command source, BRAM, consumer).
interface gbuff_stream_reader_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
);
  logic                 start;
  logic [ADDR_BITS-1:0] base_addr;
  logic [ADDR_BITS:0]   length;
  logic [ADDR_BITS-1:0] stride;
  logic                 busy;
  logic                 done;
  logic                 ram_en;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] idx;
  logic [DATA_BITS-1:0] ram_data;
  logic                 out_valid;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_ready;

  modport master (
    input  start, base_addr, length, stride, ram_data, out_ready,
    output busy, done, ram_en, wr_en, idx, out_valid, out_data
  );

  modport slave (
    output start, base_addr, length, stride, ram_data, out_ready,
    input  busy, done, ram_en, wr_en, idx, out_valid, out_data
  );
endinterface

// File: rtl/gbuff_stream_reader.sv
// Strided read controller for the global buffer: issues reads, captures the word one cycle
// later and streams it through a 2-entry FIFO, credit-gated so backpressure never loses data.
module gbuff_stream_reader #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gbuff_stream_reader_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS:0]   len_q, len_d;
  logic [ADDR_BITS:0]   issued_q, issued_d;
  logic [ADDR_BITS:0]   popped_q, popped_d;
  logic [ADDR_BITS-1:0] stride_q, stride_d;
  logic [ADDR_BITS-1:0] next_addr_q, next_addr_d;
  logic [ADDR_BITS-1:0] idx_q, idx_d;
  logic                 ram_en_q, ram_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           count_q, count_d;
  logic [DATA_BITS-1:0] head_q, head_d;
  logic [DATA_BITS-1:0] tail_q, tail_d;

  logic pop;
  logic push;
  logic issue;
  logic accept;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    stride_d    = stride_q;
    next_addr_d = next_addr_q;
    idx_d       = idx_q;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;

    pop    = (count_q != 2'd0) && bus.out_ready;
    // The read issued last cycle returns its word at this edge.
    push   = ram_en_q;
    accept = (state_q == IDLE) && !done_q && bus.start;
    // Stored plus outstanding words may never exceed the FIFO depth; a pop frees a slot now.
    issue  = (state_q == READ) && (issued_q != len_q) &&
             ((({1'b0, count_q} + {2'b00, ram_en_q}) < 3'd2) || pop);

    issued_d = issued_q + {{ADDR_BITS{1'b0}}, issue};
    popped_d = popped_q + {{ADDR_BITS{1'b0}}, pop};
    ram_en_d = issue;
    if (issue) begin
      idx_d       = next_addr_q;
      next_addr_d = next_addr_q + stride_q;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          len_d       = bus.length;
          stride_d    = bus.stride;
          next_addr_d = bus.base_addr;
          issued_d    = '0;
          popped_d    = '0;
          state_d     = (bus.length == '0) ? DONE : READ;
        end
      end
      READ:    if (issued_d == len_q) state_d = DRAIN;
      DRAIN:   if (popped_d == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == READ) || (state_d == DRAIN) || (state_d == DONE);
    done_d = (state_q == DONE);

    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = bus.ram_data;
        else                 tail_d = bus.ram_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = bus.ram_data;
        end else begin
          head_d = tail_q;
          tail_d = bus.ram_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      stride_q    <= '0;
      next_addr_q <= '0;
      idx_q       <= '0;
      ram_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      stride_q    <= stride_d;
      next_addr_q <= next_addr_d;
      idx_q       <= idx_d;
      ram_en_q    <= ram_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.wr_en     = 1'b0;
  assign bus.idx       = idx_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_data  = head_q;
endmodule

// File: tb/tb_gbuff_stream_reader.sv
// Randomized bench for gbuff_stream_reader: a negedge BRAM model plus a reference that
// derives the expected address/word sequence of each command directly from its parameters.
module tb_gbuff_stream_reader;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] mem [256];

  gbuff_stream_reader_if #(.ADDR_BITS(8), .DATA_BITS(8)) bus ();

  gbuff_stream_reader #(.ADDR_BITS(8), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.ram_en && !bus.wr_en) bus.ram_data <= mem[bus.idx];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready always high; 1: random out_ready; 2: 6-cycle stall after second word.
  // ghost: cycle index at which a conflicting start is pulsed (-1 = none).
  task automatic run_cmd(input logic [7:0] b, input logic [8:0] l, input logic [7:0] s,
                         input int mode, input int ghost);
    logic [7:0] addr_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] prev_data;
    bit         prev_hold;
    bit         got_done;
    int         issues, pops, cyc, stall, budget, done_cyc, a;

    for (int k = 0; k < int'(l); k++) begin
      a = (int'(b) + k * int'(s)) & 255;
      addr_q.push_back(a[7:0]);
      exp_q.push_back(mem[a[7:0]]);
    end
    issues = 0; pops = 0; stall = 0; got_done = 0; prev_hold = 0; prev_data = '0;
    done_cyc = -1;
    budget = int'(l) * 8 + 40;

    bus.base_addr = b; bus.length = l; bus.stride = s; bus.start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!got_done && cyc < budget) begin
      if (cyc == ghost) begin
        bus.start = 1'b1; bus.base_addr = ~b; bus.length = 9'd5; bus.stride = 8'd7;
      end else begin
        bus.start = 1'b0;
      end
      check("wr_en", bus.wr_en, 1'b0);
      if (cyc == 1 && l != 0) check("first_issue", {bus.ram_en, bus.idx}, {1'b1, b});
      if (cyc == 2 && l != 0) check("first_valid", bus.out_valid, 1'b1);
      if (l == 0) check("noop_valid", bus.out_valid, 1'b0);
      if (bus.ram_en) begin
        if (issues < addr_q.size()) check("idx", bus.idx, addr_q[issues]);
        else check("extra_issue", issues, addr_q.size());
        issues++;
      end
      check("credit", (issues - pops) <= 2, 1'b1);
      if (prev_hold) check("hold_data", bus.out_data, prev_data);
      if (bus.done) begin
        got_done = 1;
        done_cyc = cyc;
        check("done_busy", bus.busy, 1'b0);
        check("done_pops", pops, l);
        check("done_issues", issues, l);
        if (mode == 0) check("done_cycle", cyc, (l == 0) ? 1 : int'(l) + 3);
      end else begin
        if (cyc > 0 && cyc < int'(l) + 2) check("busy", bus.busy, 1'b1);
        case (mode)
          0:       bus.out_ready = 1'b1;
          1:       bus.out_ready = ($urandom_range(0, 3) != 0);
          default: begin
            if (pops >= 2 && stall < 6) begin bus.out_ready = 1'b0; stall++; end
            else bus.out_ready = 1'b1;
          end
        endcase
        if (bus.out_valid && bus.out_ready) begin
          if (pops < exp_q.size()) check("out_data", bus.out_data, exp_q[pops]);
          else check("extra_word", pops, exp_q.size());
          pops++;
        end
        prev_hold = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    check("timeout", got_done, 1'b1);
    @(posedge clk); #1;
    check("single_done", bus.done, 1'b0);
    check("idle_state", {bus.busy, bus.ram_en, bus.out_valid}, 3'b000);
    $display("cmd base=%02h len=%0d stride=%02h mode=%0d words=%0d done_cyc=%0d",
             b, l, s, mode, pops, done_cyc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      bus.busy,      1'b0);
    check({tag, "_done"},      bus.done,      1'b0);
    check({tag, "_ram_en"},    bus.ram_en,    1'b0);
    check({tag, "_idx"},       bus.idx,       8'h00);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_out_data"},  bus.out_data,  8'h00);
    check({tag, "_wr_en"},     bus.wr_en,     1'b0);
  endtask

  initial begin
    int cyc;
    checks = 0; errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.stride = '0;
    bus.out_ready = 1'b0; bus.ram_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(8'h10, 9'd4, 8'h01, 0, 3);
    run_cmd(8'hFE, 9'd4, 8'h01, 0, -1);
    run_cmd(8'h00, 9'd3, 8'h03, 0, -1);
    run_cmd(8'hF0, 9'd2, 8'h20, 0, -1);
    run_cmd(8'h20, 9'd8, 8'h01, 2, -1);
    run_cmd(8'h33, 9'd0, 8'h01, 0, 0);

    // Abort a 6-word command while its third read is in flight.
    bus.base_addr = 8'h80; bus.length = 9'd6; bus.stride = 8'h01;
    bus.start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0;
    while (cyc < 3) begin @(posedge clk); #1; cyc++; end
    check("abort_third_issue", {bus.ram_en, bus.idx}, {1'b1, 8'h82});
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset asserted mid-command at third in-flight word");
    run_cmd(8'h40, 9'd2, 8'h01, 0, -1);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int r = 0; r < 6; r++)
      run_cmd(8'($urandom), 9'($urandom_range(1, 20)), 8'($urandom), 1, $urandom_range(2, 5));
    run_cmd(8'($urandom), 9'd256, 8'h01, 1, -1);
    run_cmd(8'($urandom), 9'd16, 8'($urandom), 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
